// File: rtl/challenge_pkg.sv
// Shared types and constants for the challenge-cell test sequencer.
package challenge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_RISE_WAIT,
    ST_RISE_SET,
    ST_FALL_WAIT,
    ST_FALL_SET,
    ST_DONE
  } state_e;

  localparam logic [1:0] RD_RISE   = 2'd0;
  localparam logic [1:0] RD_FALL   = 2'd1;
  localparam logic [1:0] RD_TMO    = 2'd2;
  localparam logic [1:0] RD_TRIALS = 2'd3;

  localparam int DEFAULT_CNT_W   = 8;
  localparam int DEFAULT_TRIALS  = 16;
  localparam int DEFAULT_TIMEOUT = 200;

  // For this many cycles after a stimulus edge the synchroniser still holds
  // samples taken before the edge, so they cannot be a response to it.
  localparam int SYNC_LAT = 2;

endpackage

// File: rtl/challenge_sequencer_if.sv
// Control, result and cell-pin bundle between the tt top and the sequencer.
interface challenge_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [3:0]       settle;
  logic [1:0]       rd_sel;
  logic             dut_in;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] result;

  modport master (
    output start, settle, rd_sel, dut_out,
    input  dut_in, busy, done, pass, result
  );

  modport slave (
    input  start, settle, rd_sel, dut_out,
    output dut_in, busy, done, pass, result
  );
endinterface

// File: rtl/challenge_sequencer_sync2.sv
// Two-flop synchroniser for asynchronous inputs, clearing to 0 on reset.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Shift the raw input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/challenge_sequencer.sv
// Drives rise/fall edges into the challenge cell, times each response and
// keeps worst-case delays, timeout count and trials completed.
module challenge_sequencer
  import challenge_pkg::*;
#(
  parameter int CNT_W   = DEFAULT_CNT_W,
  parameter int TRIALS  = DEFAULT_TRIALS,
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter bit INVERT  = 1'b0
) (
  input logic                  clk,
  input logic                  rst_n,
  challenge_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TRIALS_C  = CNT_W'(TRIALS);
  localparam logic [CNT_W-1:0] LAT_C     = CNT_W'(SYNC_LAT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_e           state_q, state_d;
  logic             dutIn_q, dutIn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       settleCnt_q, settleCnt_d;
  logic [CNT_W-1:0] trial_q, trial_d;
  logic [CNT_W-1:0] riseMax_q, riseMax_d;
  logic [CNT_W-1:0] fallMax_q, fallMax_d;
  logic [CNT_W-1:0] tmoCnt_q, tmoCnt_d;

  logic             cellSync;
  logic             expected;
  logic [CNT_W-1:0] cntInc;
  logic [CNT_W-1:0] trialInc;
  logic [CNT_W-1:0] tmoSat;
  logic             cntLast;
  logic             edgeSeen;
  logic             settleDone;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.dut_out),
    .q_o   (cellSync)
  );

  assign expected   = dutIn_q ^ INVERT;
  assign cntInc     = cnt_q + ONE_C;
  assign trialInc   = trial_q + ONE_C;
  assign tmoSat     = (tmoCnt_q == '1) ? tmoCnt_q : tmoCnt_q + ONE_C;
  assign cntLast    = (cntInc == TIMEOUT_C);
  assign edgeSeen   = (cellSync == expected) && (cnt_q >= LAT_C);
  assign settleDone = (settleCnt_q == bus.settle);

  // State and statistics registers; reset forces the stimulus low at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      dutIn_q     <= 1'b0;
      cnt_q       <= '0;
      settleCnt_q <= '0;
      trial_q     <= '0;
      riseMax_q   <= '0;
      fallMax_q   <= '0;
      tmoCnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      dutIn_q     <= dutIn_d;
      cnt_q       <= cnt_d;
      settleCnt_q <= settleCnt_d;
      trial_q     <= trial_d;
      riseMax_q   <= riseMax_d;
      fallMax_q   <= fallMax_d;
      tmoCnt_q    <= tmoCnt_d;
    end
  end

  // Next-state logic: launch an edge, time the response, settle, repeat.
  always_comb begin
    state_d     = state_q;
    dutIn_d     = dutIn_q;
    cnt_d       = cnt_q;
    settleCnt_d = settleCnt_q;
    trial_d     = trial_q;
    riseMax_d   = riseMax_q;
    fallMax_d   = fallMax_q;
    tmoCnt_d    = tmoCnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        dutIn_d = 1'b0;
        if (bus.start) begin
          riseMax_d = '0;
          fallMax_d = '0;
          tmoCnt_d  = '0;
          trial_d   = '0;
          cnt_d     = '0;
          state_d   = ST_PRE;
        end
      end
      ST_PRE: begin
        dutIn_d = 1'b0;
        if (cellSync == expected || cntLast) begin
          if (cellSync != expected) tmoCnt_d = tmoSat;
          dutIn_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_RISE_WAIT;
        end else begin
          cnt_d = cntInc;
        end
      end
      ST_RISE_WAIT, ST_FALL_WAIT: begin
        if (edgeSeen || cntLast) begin
          if (!edgeSeen) begin
            tmoCnt_d = tmoSat;
          end else if (state_q == ST_RISE_WAIT) begin
            if (cntInc > riseMax_q) riseMax_d = cntInc;
          end else begin
            if (cntInc > fallMax_q) fallMax_d = cntInc;
          end
          settleCnt_d = '0;
          state_d     = (state_q == ST_RISE_WAIT) ? ST_RISE_SET : ST_FALL_SET;
        end else begin
          cnt_d = cntInc;
        end
      end
      ST_RISE_SET: begin
        if (settleDone) begin
          dutIn_d = 1'b0;
          cnt_d   = '0;
          state_d = ST_FALL_WAIT;
        end else begin
          settleCnt_d = settleCnt_q + 4'd1;
        end
      end
      ST_FALL_SET: begin
        if (settleDone) begin
          trial_d = trialInc;
          cnt_d   = '0;
          if (trialInc == TRIALS_C) begin
            dutIn_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            dutIn_d = 1'b1;
            state_d = ST_RISE_WAIT;
          end
        end else begin
          settleCnt_d = settleCnt_q + 4'd1;
        end
      end
      default: begin
        dutIn_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags and the result read-back mux.
  always_comb begin
    bus.dut_in = dutIn_q;
    bus.busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    bus.done   = (state_q == ST_DONE);
    bus.pass   = (state_q == ST_DONE) && (tmoCnt_q == '0);
    case (bus.rd_sel)
      RD_RISE: bus.result = riseMax_q;
      RD_FALL: bus.result = fallMax_q;
      RD_TMO:  bus.result = tmoCnt_q;
      default: bus.result = trial_q;
    endcase
  end

endmodule

// File: doc/challenge_sequencer.md
Name: challenge_sequencer

Overview:
Digital test sequencer for the analog challenge cell. It drives the cell's input with a programmable number of rise/fall stimulus edges and samples the cell's digitised output through a 2-flop synchroniser. It measures the response delay of each edge in clk cycles and reports worst-case rise and fall delay, timeout count and pass/fail. It sits in the tt_um top between ui_in/uo_out and the challenge cell pins.

Parameters:
CNT_W, 8, width of delay counters and result bus
TRIALS, 16, number of rise+fall edge pairs per run (1..255)
TIMEOUT, 200, cycles in a WAIT state before an edge is declared lost (2..2^CNT_W-1)
INVERT, 0, 1 = cell is inverting: expected output is ~dut_in

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle run request; honoured only in IDLE or DONE
settle  in  4  idle cycles inserted after every measured edge (0..15)
rd_sel  in  2  result select: 0 max rise delay, 1 max fall delay, 2 timeout count, 3 trials completed
dut_in  out  1  stimulus to the challenge cell input
dut_out  in  1  challenge cell output, asynchronous
busy  out  1  high from the cycle after an accepted start until DONE is entered
done  out  1  high in DONE; sticky until the next start or reset
pass  out  1  done && timeout count == 0
result  out  CNT_W  value selected by rd_sel, combinational mux of registers

Behaviour:
- Reset (async, rst_n=0): state IDLE, dut_in=0, sync flops=0, all counters and stats=0, busy=0, done=0, pass=0.
- Synchroniser: s1<=dut_out, s2<=s1. The FSM only ever uses s2. expected = dut_in ^ INVERT.
- States: IDLE, PRE, RISE_WAIT, RISE_SET, FALL_WAIT, FALL_SET, DONE.
- IDLE/DONE + start: clear stats, trial=0, enter PRE. Start is ignored in every other state.
- PRE: dut_in=0. Wait until s2 == expected for the low level, bounded by TIMEOUT; timeout here counts as one timeout. Then go to RISE_WAIT with dut_in<=1 and cnt<=0.
- RISE_WAIT/FALL_WAIT, each cycle:
  - if s2 == expected: delay = cnt+1; update max (rise or fall); go to *_SET.
  - else if cnt+1 == TIMEOUT: timeout_cnt++ (saturating at 2^CNT_W-1); go to *_SET.
  - else cnt++.
- Loopback (dut_out=dut_in, INVERT=0) must measure delay 3. The cell delay adds directly in cycles, quantised up.
- RISE_SET/FALL_SET: hold dut_in for settle cycles (0 = leave after 1 cycle). RISE_SET exits to FALL_WAIT with dut_in<=0, cnt<=0. FALL_SET increments trial; if trial == TRIALS go to DONE, else go to RISE_WAIT with dut_in<=1, cnt<=0.
- dut_in toggles only on the *_WAIT entry edge; it is glitch-free because it is a single register.
- Max delays are stored as CNT_W bits; a timed-out edge does not update max.
- DONE: dut_in=0, done=1, busy=0. Stats are held until the next start.
- Reset mid-run returns everything to reset values immediately (dut_in low asynchronously).
- dut_out changing during a *_SET state is ignored (no glitch counting).

Decomposition:
- Package challenge_pkg: state enum, rd_sel encodings (RD_RISE=0, RD_FALL=1, RD_TMO=2, RD_TRIALS=3), default TIMEOUT/TRIALS constants.
- Sub-module sync2 (2-flop synchroniser, async reset to 0), reused for other tt inputs.

Test Plan:
- Loopback, INVERT=0, TRIALS=4, settle=0: start -> done after run; rise max=3, fall max=3, timeouts=0, trials=4, pass=1.
- Model delays dut_out by 10 clk on rise and 20 on fall: rise max=12 or 13 (synchroniser phase), fall max=22 or 23, pass=1.
- INVERT=0 with an inverting model (dut_out=~dut_in), TIMEOUT=20, TRIALS=2: PRE times out, every edge times out; timeouts=5, pass=0, run ends (no hang).
- Pulse start again while busy -> ignored; trial count and stats are unaffected; done asserts exactly once.
- Assert rst_n low during FALL_WAIT -> dut_in=0 asynchronously, busy=0, all results 0. A new start then completes normally.
- settle=15, TRIALS=1, loopback: dut_in high-pulse width = 3 + 16 cycles; rd_sel 0..3 read back 3, 3, 0, 1.
